// File: rtl/neuron_sched_pkg.sv
// Shared types and SRAM word layout for the neuron update scheduler.
package neuron_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR
   } state_e;

   localparam int unsigned WEIGHT_W = 4;
   localparam int unsigned STATE_W  = 12;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned WORD_W   = STATE_W + 2 * CNT_W;

   localparam int unsigned STATE_LSB = 0;
   localparam int unsigned PRE_LSB   = STATE_LSB + STATE_W;
   localparam int unsigned POST_LSB  = PRE_LSB + CNT_W;

   // Field order matches the SRAM word: post in the MSBs, membrane state in the LSBs.
   typedef struct packed {
      logic [CNT_W-1:0]   post;
      logic [CNT_W-1:0]   pre;
      logic [STATE_W-1:0] state;
   } sram_word_t;

   function automatic sram_word_t pack_word(
      input logic [CNT_W-1:0]   post,
      input logic [CNT_W-1:0]   pre,
      input logic [STATE_W-1:0] state
   );
      sram_word_t w;
      w.post  = post;
      w.pre   = pre;
      w.state = state;
      return w;
   endfunction

endpackage

// File: rtl/neuron_sched_if.sv
// Request, SRAM, datapath and spike signals of the neuron scheduler.
interface neuron_sched_if #(
   parameter int unsigned ADDR_W = 8
);
   import neuron_sched_pkg::*;

   logic                syn_req;
   logic [ADDR_W-1:0]   syn_addr;
   logic [WEIGHT_W-1:0] syn_weight;
   logic                syn_ack;

   logic                tref_req;
   logic                tref_ack;

   logic                sram_cs;
   logic                sram_we;
   logic [ADDR_W-1:0]   sram_addr;
   logic [WORD_W-1:0]   sram_wdata;
   logic [WORD_W-1:0]   sram_rdata;

   logic [STATE_W-1:0]  neur_state;
   logic [CNT_W-1:0]    neur_pre_cnt;
   logic [CNT_W-1:0]    neur_post_cnt;
   logic [WEIGHT_W-1:0] neur_weight;
   logic                neur_syn_evt;
   logic                neur_tref;
   logic [STATE_W-1:0]  neur_state_next;
   logic [CNT_W-1:0]    neur_pre_next;
   logic [CNT_W-1:0]    neur_post_next;
   logic                neur_spike;

   logic                spk_valid;
   logic [ADDR_W-1:0]   spk_addr;
   logic                spk_ready;

   logic                busy;

   modport master (
      input  syn_req, syn_addr, syn_weight, tref_req,
      input  sram_rdata,
      input  neur_state_next, neur_pre_next, neur_post_next, neur_spike,
      input  spk_ready,
      output syn_ack, tref_ack,
      output sram_cs, sram_we, sram_addr, sram_wdata,
      output neur_state, neur_pre_cnt, neur_post_cnt, neur_weight, neur_syn_evt, neur_tref,
      output spk_valid, spk_addr,
      output busy
   );

   modport slave (
      output syn_req, syn_addr, syn_weight, tref_req,
      output sram_rdata,
      output neur_state_next, neur_pre_next, neur_post_next, neur_spike,
      output spk_ready,
      input  syn_ack, tref_ack,
      input  sram_cs, sram_we, sram_addr, sram_wdata,
      input  neur_state, neur_pre_cnt, neur_post_cnt, neur_weight, neur_syn_evt, neur_tref,
      input  spk_valid, spk_addr,
      input  busy
   );

endinterface

// File: rtl/neuron_sched_spk_out_reg.sv
// Single-entry spike output register with valid/ready handshake.
module spk_out_reg #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] addr
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // A new spike takes priority over the clearing handshake in the same cycle.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = load_addr;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign valid = valid_q;
   assign addr  = addr_q;

endmodule

// File: rtl/neuron_sched.sv
// Neuron state scheduler: read-modify-write of neuron SRAM for synaptic
// events and time-reference sweeps through an external IF datapath.
module neuron_sched
   import neuron_sched_pkg::*;
#(
   parameter int unsigned N_NEUR = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   neuron_sched_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEUR - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WEIGHT_W-1:0] weight_q, weight_d;
   logic                sweep_q, sweep_d;

   logic                spk_free;
   logic                in_wr;
   logic                spk_load;
   sram_word_t          rd_word;
   sram_word_t          wr_word;

   assign spk_free = !bus.spk_valid || bus.spk_ready;
   assign in_wr    = (state_q == ST_WR);
   assign rd_word  = sram_word_t'(bus.sram_rdata);
   assign wr_word  = pack_word(bus.neur_post_next, bus.neur_pre_next, bus.neur_state_next);
   assign spk_load = in_wr && bus.neur_spike;

   // sweep_q marks both a sweep in flight and that the current RD/WR belongs to it.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      weight_d = weight_q;
      sweep_d  = sweep_q;
      case (state_q)
         ST_IDLE: begin
            if (spk_free) begin
               if (sweep_q) begin
                  state_d = ST_RD;
                  addr_d  = cnt_q;
               end else if (bus.tref_req) begin
                  state_d = ST_RD;
                  sweep_d = 1'b1;
                  addr_d  = cnt_q;
               end else if (bus.syn_req) begin
                  state_d  = ST_RD;
                  addr_d   = bus.syn_addr;
                  weight_d = bus.syn_weight;
               end
            end
         end
         ST_RD: begin
            state_d = ST_WR;
         end
         ST_WR: begin
            state_d = ST_IDLE;
            if (sweep_q) begin
               if (addr_q == LAST_ADDR) begin
                  cnt_d   = '0;
                  sweep_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
                  // A spike produced now occupies the slot, so the next neuron waits in IDLE.
                  if (spk_free && !bus.neur_spike) begin
                     state_d = ST_RD;
                     addr_d  = cnt_q + ADDR_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         weight_q <= '0;
         sweep_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         weight_q <= weight_d;
         sweep_q  <= sweep_d;
      end
   end

   always_comb begin
      bus.sram_cs       = 1'b0;
      bus.sram_we       = 1'b0;
      bus.sram_addr     = addr_q;
      bus.sram_wdata    = '0;
      bus.neur_state    = '0;
      bus.neur_pre_cnt  = '0;
      bus.neur_post_cnt = '0;
      bus.neur_weight   = '0;
      bus.neur_syn_evt  = 1'b0;
      bus.neur_tref     = 1'b0;
      bus.syn_ack       = 1'b0;
      bus.tref_ack      = 1'b0;
      bus.busy          = (state_q != ST_IDLE);
      case (state_q)
         ST_RD: begin
            bus.sram_cs = 1'b1;
         end
         ST_WR: begin
            bus.sram_cs       = 1'b1;
            bus.sram_we       = 1'b1;
            bus.sram_wdata    = wr_word;
            bus.neur_state    = rd_word.state;
            bus.neur_pre_cnt  = rd_word.pre;
            bus.neur_post_cnt = rd_word.post;
            bus.neur_weight   = sweep_q ? '0 : weight_q;
            bus.neur_syn_evt  = !sweep_q;
            bus.neur_tref     = sweep_q;
            bus.syn_ack       = !sweep_q;
            bus.tref_ack      = sweep_q && (addr_q == LAST_ADDR);
         end
         default: begin
         end
      endcase
   end

   spk_out_reg #(
      .ADDR_W (ADDR_W)
   ) u_spk_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (spk_load),
      .load_addr (addr_q),
      .ready     (bus.spk_ready),
      .valid     (bus.spk_valid),
      .addr      (bus.spk_addr)
   );

endmodule

// File: doc/neuron_sched.md
NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 Parameters SHALL be: N_NEUR, default 256, number of neurons; ADDR_W, default 8, neuron address width (2^ADDR_W >= N_NEUR).
REQ-002 CLK  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SYN_REQ  in  1  synaptic event request; held high until SYN_ACK.
REQ-005 SYN_ADDR  in  ADDR_W  target neuron; SYN_WEIGHT  in  4  synaptic weight; both stable while SYN_REQ=1.
REQ-006 SYN_ACK  out  1  one-cycle pulse: synaptic update written.
REQ-007 TREF_REQ  in  1  time-reference sweep request; held high until TREF_ACK.
REQ-008 TREF_ACK  out  1  one-cycle pulse: sweep of all N_NEUR neurons done.
REQ-009 SRAM_CS, SRAM_WE  out  1 each; SRAM_ADDR  out  ADDR_W; SRAM_WDATA  out  18; SRAM_RDATA  in  18; synchronous state SRAM, 1-cycle read latency.
REQ-010 NEUR_STATE out 12, NEUR_PRE_CNT out 3, NEUR_POST_CNT out 3, NEUR_WEIGHT out 4, NEUR_SYN_EVT out 1, NEUR_TREF out 1: operands to the shared combinational IF neuron datapath.
REQ-011 NEUR_STATE_NEXT in 12, NEUR_PRE_NEXT in 3, NEUR_POST_NEXT in 3, NEUR_SPIKE in 1: datapath results.
REQ-012 SPK_VALID out 1, SPK_ADDR out ADDR_W, SPK_READY in 1: spike output, valid/ready.
REQ-013 BUSY out 1: FSM not in IDLE.

Function
REQ-014 SRAM word SHALL be {post_cnt[17:15], pre_cnt[14:12], state[11:0]}.
REQ-015 FSM states SHALL be IDLE, RD, WR; SRAM_CS/SRAM_WE SHALL be Moore outputs: RD -> CS=1,WE=0; WR -> CS=1,WE=1; IDLE -> CS=0,WE=0.
REQ-016 IDLE -> RD SHALL occur only when a request is pending AND spike slot is free (SPK_VALID=0 or SPK_READY=1 in that cycle).
REQ-017 Arbitration in IDLE: TREF_REQ SHALL win over SYN_REQ when both high; a started sweep SHALL NOT be preempted.
REQ-018 Synaptic op: IDLE(t) -> RD(t+1, addr=SYN_ADDR) -> WR(t+2) -> IDLE(t+3); SYN_ACK=1 in the WR cycle only.
REQ-019 In WR, NEUR_* operands SHALL come from SRAM_RDATA fields and latched op registers; SRAM_WDATA = {NEUR_POST_NEXT, NEUR_PRE_NEXT, NEUR_STATE_NEXT}, same address as RD.
REQ-020 Synaptic op: NEUR_SYN_EVT=1, NEUR_TREF=0, NEUR_WEIGHT=latched SYN_WEIGHT; sweep: NEUR_SYN_EVT=0, NEUR_TREF=1, NEUR_WEIGHT=0; outside WR all NEUR_* =0.
REQ-021 Sweep: address counter 0..N_NEUR-1, alternating RD/WR per neuron; after WR of address k<N_NEUR-1 SHALL go to RD(k+1) if spike slot free, else IDLE-hold (counter kept) until free; sweep takes 2*N_NEUR cycles unstalled.
REQ-022 TREF_ACK=1 in WR of address N_NEUR-1; counter SHALL wrap to 0.
REQ-023 NEUR_SPIKE=1 in WR SHALL load SPK_VALID=1, SPK_ADDR=current address next cycle; SPK_VALID SHALL clear on cycle after SPK_VALID&SPK_READY unless reloaded.
REQ-024 REQ-016/REQ-021 gating SHALL guarantee no spike is lost or overwritten.
REQ-025 SYN_REQ arriving mid-sweep SHALL wait; served at first IDLE after TREF_ACK if TREF_REQ low.

Reset
REQ-026 RST_N=0 SHALL force: state IDLE, counter 0, SYN_ACK=0, TREF_ACK=0, SPK_VALID=0, SPK_ADDR=0, BUSY=0, SRAM_CS=0, SRAM_WE=0; in-flight op or sweep abandoned, SRAM contents untouched.
REQ-027 After deassertion, an interrupted TREF_REQ still high SHALL restart the sweep at address 0.

Structure
REQ-028 Package neuron_sched_pkg SHALL hold FSM state enum, SRAM word field offsets/widths, weight width.
REQ-029 One sub-module spk_out_reg SHALL implement the spike valid/ready output register; datapath is external.

Verification
REQ-030 SYN_REQ, addr 5, weight 7, RDATA state 512 (cnts 0) -> RD addr 5 at t+1, WR at t+2 with WDATA = datapath result, SYN_ACK at t+2 only.
REQ-031 TREF_REQ, N_NEUR=4, no spikes -> 8 cycles RD/WR addr 0,1,2,3, TREF_ACK with WR addr 3, then IDLE.
REQ-032 TREF_REQ and SYN_REQ same cycle -> full sweep first, then syn op; SYN_ACK after TREF_ACK.
REQ-033 Sweep with NEUR_SPIKE at addr 1 and 2, SPK_READY=0 for 10 cycles -> SPK_ADDR=1 held, FSM stalls before RD addr 2, resumes on SPK_READY; spike addr 2 emitted after.
REQ-034 RST_N low during WR of sweep addr 2 -> all outputs at reset values immediately; TREF_REQ held -> sweep restarts at addr 0.
